// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the CPU-side fetch/data handshakes and the SRAM-side signals used by
// mem_port_arbiter.
//
// Signal groups:
//   Fetch port : i_req, i_addr          (requester -> arbiter)
//                i_ready, i_rdata       (arbiter -> requester)
//   Data port  : d_req, d_we, d_addr, d_wdata (requester -> arbiter)
//                d_ready, d_rdata       (arbiter -> requester)
//   SRAM       : mem_read, mem_write, mem_addr, mem_din (arbiter -> SRAM)
//                mem_dout               (SRAM -> arbiter)
//   Status     : busy                   (arbiter -> outside)
//
// Modports:
//   master : the environment around the arbiter (CPU core plus SRAM)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                     i_req;
    logic [AddrWidth-1:0]     i_addr;
    logic                     i_ready;
    logic [DataWidth-1:0]     i_rdata;

    logic                     d_req;
    logic [DataWidth/8-1:0]   d_we;
    logic [AddrWidth-1:0]     d_addr;
    logic [DataWidth-1:0]     d_wdata;
    logic                     d_ready;
    logic [DataWidth-1:0]     d_rdata;

    logic                     mem_read;
    logic [DataWidth/8-1:0]   mem_write;
    logic [AddrWidth-1:0]     mem_addr;
    logic [DataWidth-1:0]     mem_din;
    logic [DataWidth-1:0]     mem_dout;

    logic                     busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_din, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_read, mem_write, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified SRAM between the instruction-fetch port and
// the data (load/store) port. One transaction is outstanding at a time: the
// winner's request is latched in IDLE, driven to the SRAM for MEM_LATENCY
// ACCESS cycles, and answered with a one-cycle ready pulse in RESP.
// The data port has priority, but after STARVE_LIMIT consecutive data grants
// with a fetch waiting, the fetch is served.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (fetch port, data port, SRAM, busy)
//
// Parameters:
//   AddrWidth    : address width of both requesters and the SRAM
//   DataWidth    : data width, byte strobes are DataWidth/8 wide
//   MEM_LATENCY  : ACCESS cycles per transaction (1..7)
//   STARVE_LIMIT : max consecutive data grants while a fetch waits (1..15)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int StrbWidth = DataWidth / 8;

    localparam logic [2:0] CntLast   = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] StreakMax = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                 state, state_next;
    logic [2:0]             cnt, cnt_next;
    logic [3:0]             streak, streak_next;
    // owner: 0 = fetch port, 1 = data port
    logic                   owner, owner_next;
    logic [AddrWidth-1:0]   addr_q, addr_next;
    logic [StrbWidth-1:0]   we_q, we_next;
    logic [DataWidth-1:0]   wdata_q, wdata_next;
    logic [DataWidth-1:0]   rdata_q, rdata_next;

    logic                   grant_d;
    logic                   grant_i;
    logic                   in_access;
    logic                   in_resp;

    // Data wins unless a fetch is waiting and the data streak has hit its limit.
    always_comb begin
        grant_d = bus.d_req && !(bus.i_req && (streak == StreakMax));
        grant_i = bus.i_req && !grant_d;
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        streak_next = streak;
        owner_next  = owner;
        addr_next   = addr_q;
        we_next     = we_q;
        wdata_next  = wdata_q;
        rdata_next  = rdata_q;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    owner_next = 1'b1;
                    addr_next  = bus.d_addr;
                    we_next    = bus.d_we;
                    wdata_next = bus.d_wdata;
                    cnt_next   = 3'd0;
                    state_next = ACCESS;
                    if (bus.i_req) begin
                        streak_next = (streak == StreakMax) ? StreakMax : streak + 4'd1;
                    end else begin
                        streak_next = 4'd0;
                    end
                end else if (grant_i) begin
                    // A fetch is a plain read; store fields are cleared.
                    owner_next  = 1'b0;
                    addr_next   = bus.i_addr;
                    we_next     = '0;
                    wdata_next  = '0;
                    cnt_next    = 3'd0;
                    state_next  = ACCESS;
                    streak_next = 4'd0;
                end
            end

            ACCESS: begin
                cnt_next = cnt + 3'd1;
                if (cnt == CntLast) begin
                    // mem_dout is valid at the edge that ends the last ACCESS cycle.
                    rdata_next = (we_q == '0) ? bus.mem_dout : '0;
                    state_next = RESP;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            streak  <= 4'd0;
            owner   <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            streak  <= streak_next;
            owner   <= owner_next;
            addr_q  <= addr_next;
            we_q    <= we_next;
            wdata_q <= wdata_next;
            rdata_q <= rdata_next;
        end
    end

    // Outputs decode from state only; rst gates them so the SRAM and the
    // requesters see nothing from a transaction that is being dropped.
    always_comb begin
        in_access = rst && (state == ACCESS);
        in_resp   = rst && (state == RESP);

        bus.mem_read  = in_access && (we_q == '0);
        bus.mem_write = in_access ? we_q    : '0;
        bus.mem_addr  = in_access ? addr_q  : '0;
        bus.mem_din   = in_access ? wdata_q : '0;

        bus.i_ready = in_resp && !owner;
        bus.d_ready = in_resp && owner;
        bus.i_rdata = (in_resp && !owner) ? rdata_q : '0;
        bus.d_rdata = (in_resp && owner)  ? rdata_q : '0;

        bus.busy = in_access || in_resp;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with MEM_LATENCY=2, STARVE_LIMIT=2.
// Single-requester transactions come from a vector table; arbitration, starvation
// and reset-drop cases are hand-written sequences. Expected responses are queued
// when a request is driven and popped by a monitor when a ready pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int Lat = 2;
    localparam int Sl  = 2;

    typedef struct {
        logic        is_data;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic        exp_read;
        logic [3:0]  exp_write;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    int          checks;
    int          passes;
    int          ready_count;
    int          cyc;
    exp_t        exp_q[$];
    logic [31:0] mem_image [0:255];
    vec_t        vecs [5];

    mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    mem_port_arbiter #(
        .AddrWidth   (32),
        .DataWidth   (32),
        .MEM_LATENCY (Lat),
        .STARVE_LIMIT(Sl)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Read-only SRAM image; write contents are never read back here.
    assign bus.mem_dout = mem_image[bus.mem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Scoreboard side: every ready pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1) begin
            exp_t e;
            ready_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected ready", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp port", {31'd0, bus.d_ready}, {31'd0, e.is_data});
                checkOutput("resp rdata", bus.d_ready ? bus.d_rdata : bus.i_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic dropReqs();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        mem_image[v.addr[9:2]] = v.dout;
        bus.i_req   = !v.is_data;
        bus.i_addr  = v.is_data ? 32'h0 : v.addr;
        bus.d_req   = v.is_data;
        bus.d_we    = v.we;
        bus.d_addr  = v.is_data ? v.addr : 32'h0;
        bus.d_wdata = v.wdata;
        e.is_data = v.is_data;
        e.rdata   = v.exp_rdata;
        exp_q.push_back(e);
    endtask

    task automatic waitReady(input int budget, output logic got_d, output logic ok);
        ok    = 1'b0;
        got_d = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1) begin
                ok    = 1'b1;
                got_d = bus.d_ready;
                return;
            end
        end
        checkOutput("ready timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic got_d;
        logic ok;
        logic exp_order [6];
        int   last_cyc;
        int   base;
        exp_t e;

        checks = 0; passes = 0; ready_count = 0; cyc = 0;
        for (int i = 0; i < 256; i++) mem_image[i] = 32'h0;

        vecs[0] = '{1'b0, 4'h0, 32'h40,  32'h0,        32'h00A00093, 1'b1, 4'h0, 32'h0,        32'h00A00093};
        vecs[1] = '{1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 32'h12345678, 1'b0, 4'h3, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 4'h0, 32'h204, 32'h0,        32'hCAFEF00D, 1'b1, 4'h0, 32'h0,        32'hCAFEF00D};
        vecs[3] = '{1'b1, 4'hF, 32'h208, 32'h55AA55AA, 32'hFFFFFFFF, 1'b0, 4'hF, 32'h55AA55AA, 32'h0};
        vecs[4] = '{1'b0, 4'h0, 32'h44,  32'h0,        32'h00000013, 1'b1, 4'h0, 32'h0,        32'h00000013};

        // Reset held with a fetch pending: nothing may reach the SRAM.
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        mem_image[32'h80 >> 2] = 32'h11112222;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset mem_read", {31'd0, bus.mem_read}, 32'd0);
            checkOutput("reset i_ready", {31'd0, bus.i_ready}, 32'd0);
            checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        end
        e.is_data = 1'b0; e.rdata = 32'h11112222;
        exp_q.push_back(e);
        rst = 1'b1;
        step();
        checkOutput("post-reset mem_read", {31'd0, bus.mem_read}, 32'd1);
        checkOutput("post-reset mem_addr", bus.mem_addr, 32'h80);
        for (int i = 1; i < Lat; i++) step();
        step();
        checkOutput("post-reset i_ready", {31'd0, bus.i_ready}, 32'd1);
        dropReqs();
        step();
        checkOutput("post-reset idle busy", {31'd0, bus.busy}, 32'd0);

        // Table of single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v]);
            for (int c = 0; c < Lat; c++) begin
                step();
                checkOutput($sformatf("vec%0d c%0d mem_read", v, c), {31'd0, bus.mem_read}, {31'd0, vecs[v].exp_read});
                checkOutput($sformatf("vec%0d c%0d mem_write", v, c), {28'd0, bus.mem_write}, {28'd0, vecs[v].exp_write});
                checkOutput($sformatf("vec%0d c%0d mem_addr", v, c), bus.mem_addr, vecs[v].addr);
                checkOutput($sformatf("vec%0d c%0d mem_din", v, c), bus.mem_din, vecs[v].exp_din);
            end
            step();
            checkOutput($sformatf("vec%0d ready latency", v),
                        {31'd0, vecs[v].is_data ? bus.d_ready : bus.i_ready}, 32'd1);
            dropReqs();
            step();
            checkOutput($sformatf("vec%0d idle busy", v), {31'd0, bus.busy}, 32'd0);
        end

        // Simultaneous requests: data first, fetch granted in the IDLE after d_ready.
        mem_image[32'h200 >> 2] = 32'h0BADC0DE;
        mem_image[0]            = 32'h00000513;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h200; bus.d_wdata = 32'h0;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        e.is_data = 1'b1; e.rdata = 32'h0BADC0DE; exp_q.push_back(e);
        e.is_data = 1'b0; e.rdata = 32'h00000513; exp_q.push_back(e);
        step();
        checkOutput("both: first mem_addr", bus.mem_addr, 32'h200);
        for (int i = 1; i < Lat; i++) step();
        step();
        checkOutput("both: d_ready first", {31'd0, bus.d_ready}, 32'd1);
        bus.d_req = 1'b0;
        step();
        checkOutput("both: idle gap busy", {31'd0, bus.busy}, 32'd0);
        step();
        checkOutput("both: fetch mem_addr", bus.mem_addr, 32'h0);
        checkOutput("both: fetch mem_read", {31'd0, bus.mem_read}, 32'd1);
        for (int i = 1; i < Lat; i++) step();
        step();
        checkOutput("both: i_ready", {31'd0, bus.i_ready}, 32'd1);
        bus.i_req = 1'b0;
        step();

        // Both held: data streak of two, then the fetch gets its turn.
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        mem_image[32'h300 >> 2] = 32'hD0D0D0D0;
        mem_image[32'h304 >> 2] = 32'h1F1F1F1F;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h300; bus.d_wdata = 32'h0;
        bus.i_req = 1'b1; bus.i_addr = 32'h304;
        for (int k = 0; k < 6; k++) begin
            e.is_data = exp_order[k];
            e.rdata   = exp_order[k] ? 32'hD0D0D0D0 : 32'h1F1F1F1F;
            exp_q.push_back(e);
        end
        last_cyc = cyc;
        for (int k = 0; k < 6; k++) begin
            waitReady(12, got_d, ok);
            if (!ok) break;
            checkOutput($sformatf("starve grant %0d", k), {31'd0, got_d}, {31'd0, exp_order[k]});
            if (k > 0) checkOutput($sformatf("starve spacing %0d", k), 32'(cyc - last_cyc), 32'(Lat + 2));
            last_cyc = cyc;
            if (k == 5) dropReqs();
        end
        dropReqs();
        step();
        checkOutput("starve idle busy", {31'd0, bus.busy}, 32'd0);

        // Reset during the first ACCESS cycle drops the fetch silently.
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        step();
        checkOutput("drop: access mem_read", {31'd0, bus.mem_read}, 32'd1);
        rst = 1'b0;
        bus.i_req = 1'b0;
        #1;
        checkOutput("drop: gated mem_read", {31'd0, bus.mem_read}, 32'd0);
        step();
        checkOutput("drop: next mem_read", {31'd0, bus.mem_read}, 32'd0);
        checkOutput("drop: next busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        base = ready_count;
        repeat (6) step();
        checkOutput("drop: no ready pulse", 32'(ready_count - base), 32'd0);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
